// File: rtl/cipher_arbiter.sv
// cipher_arbiter: round-robin sharing of one encrypt/decrypt core between NREQ requesters.
// Ports: clk, rst (sync, active-high); req/req_op per requester (op 1=encrypt, 0=decrypt);
//   gnt (one-hot, ISSUE..ACK), ack (one-cycle completion); start_enc/start_dec pulses to
//   the core; enc_done/dec_done from the core; busy (not IDLE); err (timeout, with ack).
// Optional: define ARB_TIMEOUT_EN to build the TIMEOUT_CYCLES core-response timeout.
module cipher_arbiter #(
  parameter int NREQ = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_op,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] ack,
  output logic            start_enc,
  output logic            start_dec,
  input  logic            enc_done,
  input  logic            dec_done,
  output logic            busy,
  output logic            err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t state;
  logic [1:0] rr_ptr, win, pick;
  logic op, pick_op, done;

  if (NREQ < 2 || NREQ > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("cipher_arbiter: NREQ must be 2..4 and TIMEOUT_CYCLES 1..65535");
  end

  // Scan offsets from highest to lowest so the nearest requester at or after rr_ptr wins.
  always_comb begin
    int j;
    j = 0;
    pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(rr_ptr) + i;
      j = j >= NREQ ? j - NREQ : j;
      pick = |(req & (NREQ'(1) << j)) ? 2'(j) : pick;
    end
    pick_op = |(req_op & (NREQ'(1) << pick));
    done = op ? enc_done : dec_done;
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      win <= '0;
      op <= 1'b0;
      gnt <= '0;
      ack <= '0;
      start_enc <= 1'b0;
      start_dec <= 1'b0;
      busy <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err <= 1'b0;
      cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (|req) begin
          state <= ISSUE;
          win <= pick;
          op <= pick_op;
          gnt <= NREQ'(1) << pick;
          start_enc <= pick_op;
          start_dec <= !pick_op;
          busy <= 1'b1;
        end
        ISSUE: begin
          state <= WAIT;
          start_enc <= 1'b0;
          start_dec <= 1'b0;
`ifdef ARB_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        WAIT: begin
          if (done) begin
            state <= ACK;
            ack <= NREQ'(1) << win;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            state <= ACK;
            ack <= NREQ'(1) << win;
            err <= 1'b1;
          end else
            cnt <= cnt + 16'd1;
`endif
        end
        ACK: begin
          state <= IDLE;
          ack <= '0;
          gnt <= '0;
          busy <= 1'b0;
          rr_ptr <= win == 2'(NREQ - 1) ? 2'd0 : win + 2'd1;
`ifdef ARB_TIMEOUT_EN
          err <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cipher_arbiter.sv
// tb_cipher_arbiter: table-driven and scoreboarded checks of cipher_arbiter (NREQ=2).
module tb_cipher_arbiter;
  logic clk = 0;
  logic rst = 1;
  logic [1:0] req = '0, req_op = '0, gnt, ack;
  logic start_enc, start_dec, busy, err;
  logic enc_done = 0, dec_done = 0;
  int vectors = 0, miscompares = 0, cyc = 0;
  bit mon_en = 0;

  typedef struct {int win; logic op;} exp_t;
  typedef struct {logic [1:0] r; logic [1:0] o; int dly; int win; logic op;} vec_t;
  exp_t sb[$];
  vec_t tv[8];

  cipher_arbiter #(.NREQ(2), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .gnt(gnt), .ack(ack),
    .start_enc(start_enc), .start_dec(start_dec), .enc_done(enc_done),
    .dec_done(dec_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) if (mon_en) begin
    chk("start_exclusive", 32'(start_enc && start_dec), 0);
    chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
  end

  task automatic wait_start(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!(start_enc || start_dec) && lat < 40);
  endtask

  task automatic run_op(input logic [1:0] r, input logic [1:0] o, input int dly,
                        input int w, input logic eo);
    int lat, gcnt;
    exp_t e;
    sb.push_back('{win: w, op: eo});
    req = r;
    req_op = o;
    wait_start(lat);
    e = sb[0];
    chk("start_latency", lat, 1);
    chk("start_enc", start_enc, e.op);
    chk("start_dec", start_dec, !e.op);
    chk("gnt_issue", gnt, 1 << e.win);
    chk("busy_issue", busy, 1);
    gcnt = int'(gnt != 0);
    for (int k = 0; k <= dly; k++) begin
      step();
      gcnt += int'(gnt != 0);
      chk("single_start", {start_enc, start_dec}, 0);
      chk("no_early_ack", ack, 0);
    end
    if (eo) enc_done = 1; else dec_done = 1;
    step();
    enc_done = 0;
    dec_done = 0;
    gcnt += int'(gnt != 0);
    e = sb.pop_front();
    chk("ack", ack, 1 << e.win);
    chk("err_clear", err, 0);
    req = '0;
    step();
    chk("gnt_cycles", gcnt, dly + 3);
    chk("gnt_drop", gnt, 0);
    chk("busy_after", busy, 0);
    chk("ack_one_cycle", ack, 0);
  endtask

  initial begin
    int lat, last, n;
    exp_t e;
    tv[0] = '{2'b01, 2'b01, 4, 0, 1'b1};
    tv[1] = '{2'b11, 2'b00, 3, 1, 1'b0};
    tv[2] = '{2'b11, 2'b11, 0, 0, 1'b1};
    tv[3] = '{2'b01, 2'b00, 2, 0, 1'b0};
    tv[4] = '{2'b10, 2'b10, 1, 1, 1'b1};
    tv[5] = '{2'b10, 2'b00, 4, 1, 1'b0};
    tv[6] = '{2'b11, 2'b10, 1, 0, 1'b0};
    tv[7] = '{2'b11, 2'b10, 1, 1, 1'b1};

    step();
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_start", {start_enc, start_dec}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 0;
    mon_en = 1;

    foreach (tv[i]) run_op(tv[i].r, tv[i].o, tv[i].dly, tv[i].win, tv[i].op);

    // Both requesters held: grants alternate and starts are exactly 4 cycles apart.
    req = 2'b11;
    req_op = 2'b00;
    last = 0;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{win: i % 2, op: 1'b0});
      wait_start(lat);
      if (i > 0) chk("start_spacing", cyc - last, 4);
      last = cyc;
      chk("fair_gnt", gnt, 1 << (i % 2));
      chk("fair_start_dec", start_dec, 1);
      step();
      dec_done = 1;
      step();
      dec_done = 0;
      e = sb.pop_front();
      chk("fair_ack", ack, 1 << e.win);
      if (i == 3) req = '0;
    end
    step();

    // Non-matching done is ignored; completion only on enc_done.
    sb.push_back('{win: 0, op: 1'b1});
    req = 2'b01;
    req_op = 2'b01;
    step();
    chk("wd_start_enc", start_enc, 1);
    step();
    dec_done = 1;
    step();
    dec_done = 0;
    chk("wd_no_ack", ack, 0);
    chk("wd_gnt_held", gnt, 2'b01);
    step();
    enc_done = 1;
    step();
    enc_done = 0;
    e = sb.pop_front();
    chk("wd_ack", ack, 1 << e.win);
    req = '0;
    step();

    // req_op changes after the op is latched.
    sb.push_back('{win: 0, op: 1'b1});
    req = 2'b01;
    req_op = 2'b01;
    step();
    req_op = 2'b00;
    chk("opchg_start_enc", start_enc, 1);
    chk("opchg_start_dec", start_dec, 0);
    step();
    dec_done = 1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("opchg_no_ack", ack, 0);
      chk("opchg_no_dec", start_dec, 0);
    end
    dec_done = 0;
    enc_done = 1;
    step();
    enc_done = 0;
    e = sb.pop_front();
    chk("opchg_ack", ack, 1 << e.win);
    req = '0;
    step();

    // Reset during WAIT abandons the operation.
    req = 2'b01;
    req_op = 2'b00;
    step();
    chk("rw_start_dec", start_dec, 1);
    step();
    rst = 1;
    step();
    rst = 0;
    req = '0;
    chk("rw_gnt", gnt, 0);
    chk("rw_ack", ack, 0);
    chk("rw_busy", busy, 0);
    dec_done = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rw_never_ack", ack, 0);
    end
    dec_done = 0;
    run_op(2'b10, 2'b10, 1, 1, 1'b1);

`ifdef ARB_TIMEOUT_EN
    // Core never answers: timeout ack+err 11 cycles after ISSUE, then the other requester.
    req = 2'b11;
    req_op = 2'b00;
    wait_start(lat);
    chk("to_gnt", gnt, 2'b01);
    n = 0;
    do begin
      step();
      n++;
    end while (ack == 0 && n < 40);
    chk("to_latency", n, 11);
    chk("to_ack", ack, 2'b01);
    chk("to_err", err, 1);
    step();
    chk("to_ack_clear", ack, 0);
    chk("to_err_clear", err, 0);
    wait_start(lat);
    chk("to_next_gnt", gnt, 2'b10);
    step();
    dec_done = 1;
    step();
    dec_done = 0;
    chk("to_next_ack", ack, 2'b10);
    req = '0;
    step();
`else
    // Without the timeout the arbiter waits for the core forever.
    req = 2'b01;
    req_op = 2'b01;
    wait_start(lat);
    chk("nto_start", start_enc, 1);
    n = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      n += int'(busy === 1'b1 && err === 1'b0 && ack === 2'b00);
    end
    chk("nto_waits", n, 50);
    rst = 1;
    req = '0;
    step();
    rst = 0;
    chk("nto_reset_busy", busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cipher_arbiter.md
Name: cipher_arbiter

Overview:
- Shares the single encrypt/decrypt core between independent requesters, e.g. the access FSM (password verify/enroll) and the flash boot-load path.
- Each requester asks for one encrypt or decrypt operation.
- The block arbitrates round-robin, issues one start pulse to the core, waits for the matching done, then returns a one-cycle ack to the winner.
- It sits between the requesters and the core's start_enc/start_dec/enc_done/dec_done interface.

Parameters:
- NREQ, 2, number of requesters (2..4).
- TIMEOUT_CYCLES, 255, core-response timeout in clk cycles. Used only with ARB_TIMEOUT_EN; 1..2^16-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  request per requester; held high until its ack.
- req_op  input  NREQ  op per requester: 1 = encrypt, 0 = decrypt; held stable while req is high.
- gnt  output  NREQ  one-hot grant, high from ISSUE through ACK.
- ack  output  NREQ  one-cycle completion pulse to the granted requester.
- start_enc  output  1  one-cycle start pulse to the core, encrypt.
- start_dec  output  1  one-cycle start pulse to the core, decrypt.
- enc_done  input  1  core encrypt complete (level or pulse).
- dec_done  input  1  core decrypt complete (level or pulse).
- busy  output  1  high in any state other than IDLE.
- err  output  1  one-cycle timeout flag, coincident with ack. Tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset: reset is synchronous and active-high on rst; one clock, clk. While rst is high at a clk edge:
  - state goes to IDLE and rr_ptr to 0;
  - gnt, ack, start_enc, start_dec, busy and err are all 0 from the next cycle;
  - the op latch and timeout counter clear.
  - Reset mid-operation abandons the operation: no ack, and the core is not informed.
- All outputs are registered.
- State machine:
  - IDLE:
    - If any req bit is high, select the winner: the first set bit searching from rr_ptr upward, wrapping modulo NREQ.
    - Latch winner index and req_op[winner], then go to ISSUE.
    - If no req bit is high, stay in IDLE.
  - ISSUE, exactly 1 cycle:
    - gnt[winner]=1; start_enc = latched op, start_dec = !latched op.
    - Go to WAIT.
  - WAIT:
    - gnt held; done inputs are sampled here only.
    - Go to ACK when the done matching the latched op is high (enc_done for encrypt, dec_done for decrypt).
    - The non-matching done is ignored.
  - ACK, 1 cycle:
    - ack[winner]=1, gnt held.
    - rr_ptr <= (winner+1) mod NREQ.
    - Go to IDLE.
- Latency: req high at edge N gives the start pulse in cycle N+1. If done is high at edge M, ack is in cycle M+1, and gnt drops in cycle M+2.
- Back-to-back: after ACK, the IDLE cycle arbitrates again, so the minimum spacing between start pulses is 4 cycles.
- Fairness: while both requesters stay asserted, grants alternate 0,1,0,1.
- req dropped mid-operation: the operation still completes and ack still pulses. The requester must ignore an ack it did not wait for.
- req_op changing after IDLE has no effect; the latched value is used.
- A done asserted during IDLE, ISSUE or ACK is ignored.
- A done level still high from the previous operation: the core guarantees done deasserts within 1 cycle of start. The arbiter does not filter it.
- start_enc and start_dec are never high together. gnt is never multi-hot.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with no matching done, go to ACK with ack[winner]=1 and err=1 for that same cycle.
  - rr_ptr still advances.
- Undefined:
  - No counter is built; WAIT lasts indefinitely; err is constant 0.

Test Plan:
- Reset, then req=01, req_op=01, enc_done high 5 cycles after start_enc:
  - gnt=01 for 7 cycles; one start_enc, no start_dec;
  - ack=01 exactly one cycle after enc_done; busy low afterwards.
- req=11 held, req_op=00, dec_done 3 cycles after each start:
  - grant order 0,1,0,1; each ack one cycle after its dec_done;
  - start pulses ≥4 cycles apart.
- Winner=0 with op=enc; pulse dec_done in WAIT, then enc_done 2 cycles later:
  - no ack on dec_done; ack=01 one cycle after enc_done.
- Assert rst during WAIT:
  - next cycle gnt=0, ack=0, busy=0, no ack ever for that operation;
  - the next request from requester 1 alone is granted at normal latency.
- Change req_op from 1 to 0 in the cycle after IDLE:
  - start_enc issued, start_dec never issued, completion on enc_done only.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=10, core never responds:
  - ack and err both high for exactly one cycle, 11 cycles after ISSUE;
  - the next request goes to the other requester if pending.
  - Without the macro: busy stays high indefinitely and err stays 0.
